// File: rtl/posit_engine_pkg.sv
// Shared types and helpers for the posit vector engine.
package posit_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_STORE  = 3'd5,
    S_DONE   = 3'd6
  } engine_state_e;

  // Number of bytes in one posit word.
  function automatic int unsigned posit_bytes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/posit_byte_shifter.sv
// Word register that either loads in parallel or shifts one byte in at the top,
// so it assembles little-endian byte streams and serialises words low byte first.
module posit_byte_shifter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 8) begin : g_one
      assign shifted = byte_i;
    end else begin : g_many
      assign shifted = {byte_i, word_q[WIDTH-1:8]};
    end
  endgenerate

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = word_i;
    end else if (shift_i) begin
      word_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/posit_vector_engine.sv
// Streams element pairs from byte memory to an external posit core and writes
// each result back, one element at a time.
module posit_vector_engine
  import posit_engine_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   io_start,
  input  logic [COUNT_WIDTH-1:0] io_op_count,
  input  logic [ADDR_WIDTH-1:0]  io_src_a_address,
  input  logic [ADDR_WIDTH-1:0]  io_src_b_address,
  input  logic [ADDR_WIDTH-1:0]  io_dst_address,
  output logic [ADDR_WIDTH-1:0]  io_address_to_read,
  input  logic [7:0]             io_read_data,
  output logic [ADDR_WIDTH-1:0]  io_address_to_write,
  output logic [7:0]             io_write_data,
  output logic                   io_write_enable,
  output logic [POSIT_WIDTH-1:0] io_core_a,
  output logic [POSIT_WIDTH-1:0] io_core_b,
  output logic                   io_core_valid,
  input  logic                   io_core_ready,
  input  logic [POSIT_WIDTH-1:0] io_core_result,
  input  logic                   io_core_result_valid,
  output logic                   io_busy,
  output logic                   io_completed,
  output logic [COUNT_WIDTH-1:0] io_processed
);

  localparam int unsigned BYTES = posit_bytes(POSIT_WIDTH);
  localparam int unsigned BC_W  = $clog2(BYTES + 1);
  localparam logic [ADDR_WIDTH-1:0] ELEM_STRIDE = ADDR_WIDTH'(BYTES);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [BC_W-1:0] DRAIN     = BC_W'(BYTES);

  engine_state_e state_q, state_d;
  logic                   start_q;
  logic [BC_W-1:0]        byte_q, byte_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] processed_q, processed_d;
  logic [ADDR_WIDTH-1:0]  a_ptr_q, a_ptr_d;
  logic [ADDR_WIDTH-1:0]  b_ptr_q, b_ptr_d;
  logic [ADDR_WIDTH-1:0]  d_ptr_q, d_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic                   core_valid_q, core_valid_d;
  logic                   busy_q, busy_d;
  logic                   completed_q, completed_d;

  logic                   start_edge;
  logic                   a_shift, b_shift, res_load, res_shift;
  logic [POSIT_WIDTH-1:0] a_word, b_word, res_word;
  logic                   unused_res_hi;

  assign start_edge = io_start & ~start_q;

  // Next-state, datapath strobes and registered-output next values.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    count_d      = count_q;
    processed_d  = processed_q;
    a_ptr_d      = a_ptr_q;
    b_ptr_d      = b_ptr_q;
    d_ptr_d      = d_ptr_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    a_shift      = 1'b0;
    b_shift      = 1'b0;
    res_load     = 1'b0;
    res_shift    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          count_d     = io_op_count;
          a_ptr_d     = io_src_a_address;
          b_ptr_d     = io_src_b_address;
          d_ptr_d     = io_dst_address;
          processed_d = '0;
          byte_d      = '0;
          if (io_op_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_LOAD_A;
            rd_addr_d = io_src_a_address;
          end
        end
      end
      // Byte j is addressed in cycle j and captured at the end of cycle j+1.
      S_LOAD_A: begin
        a_shift = (byte_q != '0);
        if (byte_q < LAST_BYTE) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        if (byte_q == DRAIN) begin
          state_d   = S_LOAD_B;
          byte_d    = '0;
          rd_addr_d = b_ptr_q;
        end else begin
          byte_d = byte_q + BC_W'(1);
        end
      end
      S_LOAD_B: begin
        b_shift = (byte_q != '0);
        if (byte_q < LAST_BYTE) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        if (byte_q == DRAIN) begin
          state_d = S_ISSUE;
          byte_d  = '0;
        end else begin
          byte_d = byte_q + BC_W'(1);
        end
      end
      S_ISSUE: begin
        if (io_core_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_core_result_valid) begin
          res_load  = 1'b1;
          state_d   = S_STORE;
          wr_addr_d = d_ptr_q;
          byte_d    = '0;
        end
      end
      S_STORE: begin
        res_shift = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        if (byte_q == LAST_BYTE) begin
          byte_d      = '0;
          processed_d = processed_q + COUNT_WIDTH'(1);
          a_ptr_d     = a_ptr_q + ELEM_STRIDE;
          b_ptr_d     = b_ptr_q + ELEM_STRIDE;
          d_ptr_d     = d_ptr_q + ELEM_STRIDE;
          if ((processed_q + COUNT_WIDTH'(1)) == count_q) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_LOAD_A;
            rd_addr_d = a_ptr_q + ELEM_STRIDE;
          end
        end else begin
          byte_d = byte_q + BC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_en_d      = (state_d == S_STORE);
    core_valid_d = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    completed_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      byte_q       <= '0;
      count_q      <= '0;
      processed_q  <= '0;
      a_ptr_q      <= '0;
      b_ptr_q      <= '0;
      d_ptr_q      <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      core_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      completed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= io_start;
      byte_q       <= byte_d;
      count_q      <= count_d;
      processed_q  <= processed_d;
      a_ptr_q      <= a_ptr_d;
      b_ptr_q      <= b_ptr_d;
      d_ptr_q      <= d_ptr_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      core_valid_q <= core_valid_d;
      busy_q       <= busy_d;
      completed_q  <= completed_d;
    end
  end

  posit_byte_shifter #(.WIDTH(POSIT_WIDTH)) u_shift_a (
    .clk    (clock),
    .rst_n  (reset_n),
    .load_i (1'b0),
    .word_i ('0),
    .shift_i(a_shift),
    .byte_i (io_read_data),
    .word_o (a_word)
  );

  posit_byte_shifter #(.WIDTH(POSIT_WIDTH)) u_shift_b (
    .clk    (clock),
    .rst_n  (reset_n),
    .load_i (1'b0),
    .word_i ('0),
    .shift_i(b_shift),
    .byte_i (io_read_data),
    .word_o (b_word)
  );

  // Result is loaded whole, then shifted down so the low byte is always the one written.
  posit_byte_shifter #(.WIDTH(POSIT_WIDTH)) u_shift_res (
    .clk    (clock),
    .rst_n  (reset_n),
    .load_i (res_load),
    .word_i (io_core_result),
    .shift_i(res_shift),
    .byte_i (8'h00),
    .word_o (res_word)
  );

  assign unused_res_hi = ^(res_word >> 8);

  assign io_address_to_read  = rd_addr_q;
  assign io_address_to_write = wr_addr_q;
  assign io_write_data       = res_word[7:0];
  assign io_write_enable     = wr_en_q;
  assign io_core_a           = a_word;
  assign io_core_b           = b_word;
  assign io_core_valid       = core_valid_q;
  assign io_busy             = busy_q;
  assign io_completed        = completed_q;
  assign io_processed        = processed_q;

endmodule

// File: tb/tb_posit_vector_engine.sv
// Scoreboard bench: memory, posit-core stub and write monitor around the engine.
module tb_posit_vector_engine;

  localparam int BYTES = 4;

  logic        clock;
  logic        reset_n;
  logic        io_start;
  logic [7:0]  io_op_count;
  logic [11:0] io_src_a_address, io_src_b_address, io_dst_address;
  logic [11:0] io_address_to_read;
  logic [7:0]  io_read_data;
  logic [11:0] io_address_to_write;
  logic [7:0]  io_write_data;
  logic        io_write_enable;
  logic [31:0] io_core_a, io_core_b;
  logic        io_core_valid, io_core_ready;
  logic [31:0] io_core_result;
  logic        io_core_result_valid;
  logic        io_busy, io_completed;
  logic [7:0]  io_processed;

  posit_vector_engine #(.POSIT_WIDTH(32), .ADDR_WIDTH(12), .COUNT_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .io_start(io_start), .io_op_count(io_op_count),
    .io_src_a_address(io_src_a_address), .io_src_b_address(io_src_b_address),
    .io_dst_address(io_dst_address), .io_address_to_read(io_address_to_read),
    .io_read_data(io_read_data), .io_address_to_write(io_address_to_write),
    .io_write_data(io_write_data), .io_write_enable(io_write_enable),
    .io_core_a(io_core_a), .io_core_b(io_core_b), .io_core_valid(io_core_valid),
    .io_core_ready(io_core_ready), .io_core_result(io_core_result),
    .io_core_result_valid(io_core_result_valid), .io_busy(io_busy),
    .io_completed(io_completed), .io_processed(io_processed)
  );

  int checks = 0;
  int failures = 0;
  bit garbage_en = 0;

  logic [7:0]  src_mem [0:4095];
  logic [7:0]  dst_mem [0:4095];
  logic [63:0] exp_ops_q [$];
  logic [19:0] exp_wr_q [$];
  int          w_q [$];
  int          l_q [$];

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Source memory: data for an address appears one cycle later.
  always @(posedge clock) io_read_data <= src_mem[io_address_to_read];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // External core stub: knows 1.0+2.0 exactly, otherwise a fixed mixing function.
  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4800_0000) return 32'h4C00_0000;
    return a + {b[15:0], b[31:16]} + 32'h0000_1357;
  endfunction

  function automatic logic [31:0] mem_word(input logic [11:0] base, input int i);
    logic [31:0] w;
    logic [11:0] ad;
    for (int k = 0; k < BYTES; k++) begin
      ad = base + 12'(i * BYTES + k);
      w[8*k +: 8] = src_mem[ad];
    end
    return w;
  endfunction

  // Write monitor: every strobe must match the next expected byte.
  initial begin : write_monitor
    forever begin
      @(negedge clock);
      if (reset_n && io_write_enable) begin
        if (exp_wr_q.size() == 0) begin
          fail_event("unexpected_write");
        end else begin
          check("write", {io_address_to_write, io_write_data}, exp_wr_q.pop_front());
        end
        dst_mem[io_address_to_write] = io_write_data;
      end
    end
  end

  // Core model: stalls ready W cycles, returns the result after L cycles, and
  // checks operands at each accepted handshake.
  initial begin : core_model
    bit v_prev, pend, hs;
    int lat, stall, wtarget;
    logic [31:0] a_prev, b_prev, opa, opb;
    io_core_ready = 0; io_core_result_valid = 0; io_core_result = 0;
    v_prev = 0; pend = 0; lat = 0; stall = 0; wtarget = 0;
    a_prev = 0; b_prev = 0; opa = 0; opb = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        io_core_ready = 0; io_core_result_valid = 0;
        v_prev = 0; pend = 0; stall = 0;
      end else begin
        hs = v_prev && io_core_ready;
        io_core_result_valid = 0;
        if (hs) begin
          if (exp_ops_q.size() == 0) fail_event("unexpected_issue");
          else check("operands", {a_prev, b_prev}, exp_ops_q.pop_front());
          pend = 1;
          lat = (l_q.size() != 0) ? l_q.pop_front() : 1;
          opa = a_prev; opb = b_prev;
        end
        if (pend) begin
          lat--;
          if (lat <= 0) begin
            io_core_result_valid = 1;
            io_core_result = core_fn(opa, opb);
            pend = 0;
          end
        end else if (garbage_en && $urandom_range(3, 0) == 0) begin
          io_core_result_valid = 1;
          io_core_result = $urandom;
        end
        if (io_core_valid) begin
          if (!v_prev) begin
            stall = 0;
            wtarget = (w_q.size() != 0) ? w_q.pop_front() : 0;
          end
          io_core_ready = (stall >= wtarget);
          if (stall < wtarget) stall++;
        end else begin
          io_core_ready = 0;
        end
        v_prev = io_core_valid; a_prev = io_core_a; b_prev = io_core_b;
      end
    end
  end

  task automatic prep_job(input int cnt, input logic [11:0] sa, input logic [11:0] sb,
                          input logic [11:0] sd, input int wlo, input int whi,
                          input int llo, input int lhi, output int exp_cyc);
    logic [31:0] a, b, r;
    logic [11:0] ad;
    int w, l;
    exp_cyc = 1;
    for (int i = 0; i < cnt; i++) begin
      w = $urandom_range(whi, wlo);
      l = $urandom_range(lhi, llo);
      w_q.push_back(w);
      l_q.push_back(l);
      exp_cyc += 2 * (BYTES + 1) + w + 1 + l + BYTES;
      a = mem_word(sa, i);
      b = mem_word(sb, i);
      exp_ops_q.push_back({a, b});
      r = core_fn(a, b);
      for (int k = 0; k < BYTES; k++) begin
        ad = sd + 12'(i * BYTES + k);
        exp_wr_q.push_back({ad, r[8*k +: 8]});
      end
    end
  endtask

  task automatic drive_start(input int cnt, input logic [11:0] sa, input logic [11:0] sb,
                             input logic [11:0] sd);
    @(negedge clock);
    io_op_count = 8'(cnt);
    io_src_a_address = sa; io_src_b_address = sb; io_dst_address = sd;
    io_start = 1;
  endtask

  task automatic run_job(input int cnt, input logic [11:0] sa, input logic [11:0] sb,
                         input logic [11:0] sd, input int wlo, input int whi,
                         input int llo, input int lhi, input bit mid);
    int exp_cyc, cyc;
    bit done;
    prep_job(cnt, sa, sb, sd, wlo, whi, llo, lhi, exp_cyc);
    drive_start(cnt, sa, sb, sd);
    cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      @(posedge clock);
      #1;
      cyc++;
      if (mid && cyc == 6) io_start = 0;
      if (mid && cyc == 9) begin
        io_op_count = 8'(cnt + 4);
        io_src_a_address = sa + 12'h040;
        io_start = 1;
      end
      if (io_completed) done = 1;
    end
    check("cycles", 64'(cyc), 64'(exp_cyc));
    check("processed", 64'(io_processed), 64'(cnt));
    check("busy_at_done", 64'(io_busy), 64'd0);
    check("completed", 64'(io_completed), 64'd1);
    io_start = 0;
    repeat (3) @(posedge clock);
    #1;
    check("writes_left", 64'(exp_wr_q.size()), 64'd0);
    check("issues_left", 64'(exp_ops_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {20'd0, io_address_to_read, io_address_to_write, io_write_data,
          io_write_enable, io_core_valid, io_busy, io_completed, io_processed}, 64'd0);
    check({tag, "_ops"}, {io_core_a, io_core_b}, 64'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int exp_cyc;
    bit seen;
    logic [11:0] sd;
    reset_n = 0; io_start = 0; io_op_count = 0;
    io_src_a_address = 0; io_src_b_address = 0; io_dst_address = 0;
    for (int i = 0; i < 4096; i++) begin
      src_mem[i] = 8'($urandom);
      dst_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    reset_n = 1;
    repeat (2) @(posedge clock);

    // Empty vector goes straight to DONE.
    run_job(0, 12'h100, 12'h200, 12'h300, 0, 0, 1, 1, 0);

    // 1.0 + 2.0 with a latency-1 adder.
    {src_mem[12'h103], src_mem[12'h102], src_mem[12'h101], src_mem[12'h100]} = 32'h4000_0000;
    {src_mem[12'h203], src_mem[12'h202], src_mem[12'h201], src_mem[12'h200]} = 32'h4800_0000;
    sd = 12'h300;
    run_job(1, 12'h100, 12'h200, sd, 0, 0, 1, 1, 0);
    check("dst_1p0_plus_2p0", 64'({dst_mem[sd + 12'd3], dst_mem[sd + 12'd2],
          dst_mem[sd + 12'd1], dst_mem[sd]}), 64'h4C00_0000);

    // Ready held low two cycles on every issue.
    run_job(3, 12'h400, 12'h500, 12'h600, 2, 2, 1, 3, 0);

    // Source and destination regions wrapping past the top of memory.
    run_job(2, 12'hFFE, 12'hFF9, 12'hFFD, 0, 1, 1, 2, 0);

    // A second start edge mid-run must be ignored.
    run_job(3, 12'h700, 12'h780, 12'h800, 0, 2, 1, 2, 1);

    // Reset while storing: outputs drop at once and nothing more is written.
    prep_job(2, 12'h900, 12'h980, 12'hA00, 0, 1, 1, 2, exp_cyc);
    drive_start(2, 12'h900, 12'h980, 12'hA00);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (io_write_enable) seen = 1;
    end
    check("store_reached", 64'(seen), 64'd1);
    #2;
    reset_n = 0;
    io_start = 0;
    #1;
    check_reset_outputs("async_rst");
    exp_wr_q.delete(); exp_ops_q.delete(); w_q.delete(); l_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    repeat (2) @(posedge clock);
    run_job(2, 12'hB00, 12'hB40, 12'hC00, 0, 1, 1, 2, 0);

    // Random jobs with spurious result strobes outside WAIT.
    garbage_en = 1;
    for (int j = 0; j < 5; j++) begin
      run_job($urandom_range(6, 1), 12'($urandom), 12'($urandom), 12'($urandom),
              0, 3, 1, 4, 0);
    end
    garbage_en = 0;

    repeat (4) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
